// File: rtl/mem_port_arbiter_pkg.sv
// cache_pkg: shared cache-line geometry, arbiter state and owner encodings
package cache_pkg;
  localparam int WORD_BITS = 32;
  localparam int LINE_BEATS = 8;
  localparam int LINE_BITS = LINE_BEATS * WORD_BITS;
  localparam int ADDR_BITS = 32;
  localparam int OFFSET_BITS = 5;
  localparam int TIMEOUT_CYCLES = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: I-cache, D-cache and line-adapter signals around the arbiter
//   master: the caches and the adapter (drive requests, ad_ready/ad_rline)
//   slave : the arbiter (drives acks, lines, adapter strobes/address/wline)
interface mem_port_arbiter_if #(
  parameter int ADDR_BITS = cache_pkg::ADDR_BITS,
  parameter int LINE_BITS = cache_pkg::LINE_BITS
);
  logic                 i_req;
  logic [ADDR_BITS-1:0] i_addr;
  logic                 i_ack;
  logic                 i_err;
  logic [LINE_BITS-1:0] i_line;
  logic                 d_req;
  logic                 d_we;
  logic [ADDR_BITS-1:0] d_addr;
  logic [LINE_BITS-1:0] d_wline;
  logic                 d_ack;
  logic                 d_err;
  logic [LINE_BITS-1:0] d_line;
  logic                 ad_re;
  logic                 ad_we;
  logic [ADDR_BITS-1:0] ad_addr;
  logic [LINE_BITS-1:0] ad_wline;
  logic                 ad_ready;
  logic [LINE_BITS-1:0] ad_rline;
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wline, ad_ready, ad_rline,
    input  i_ack, i_err, i_line, d_ack, d_err, d_line, ad_re, ad_we, ad_addr, ad_wline
  );
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wline, ad_ready, ad_rline,
    output i_ack, i_err, i_line, d_ack, d_err, d_line, ad_re, ad_we, ad_addr, ad_wline
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker (I vs D) with its own last-grant register
//   clk, rst       : clock, async active-high reset
//   req_i, req_d   : pending requests
//   en             : arbitration allowed this cycle
//   valid, grant   : a grant is issued this cycle, and to whom
module rr_arb2
  import cache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   en,
  output logic   valid,
  output owner_t grant
);
  owner_t last;
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= OWN_D;
    else if (valid) last <= grant;
  always_comb begin
    valid = en & (req_i | req_d);
    grant = (req_i & req_d) ? ((last == OWN_D) ? OWN_I : OWN_D) : (req_d ? OWN_D : OWN_I);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one cache-line adapter between I-cache fills and D-cache fills/writebacks
//   CLK, RST : clock, async active-high reset (released synchronously inside)
//   bus      : slave side of mem_port_arbiter_if (cache requests/acks, adapter strobes/data)
module mem_port_arbiter #(
  parameter int LINE_BITS = cache_pkg::LINE_BITS,
  parameter int ADDR_BITS = cache_pkg::ADDR_BITS,
  parameter int OFFSET_BITS = cache_pkg::OFFSET_BITS,
  parameter int TIMEOUT_CYCLES = cache_pkg::TIMEOUT_CYCLES
) (
  input logic CLK,
  input logic RST,
  mem_port_arbiter_if.slave bus
);
  import cache_pkg::*;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] AMASK = ~ADDR_BITS'((64'd1 << OFFSET_BITS) - 64'd1);
  logic [1:0] rs;
  logic rst;
  arb_state_t state, nxt;
  owner_t owner_q, grant;
  logic gv, we_q, err_q, timeout, rsp, act;
  logic [CW-1:0] cnt;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LINE_BITS-1:0] wline_q, rline_q;
  // asserts with RST immediately, releases two clocks later on a clean edge
  always_ff @(posedge CLK or posedge RST)
    if (RST) rs <= 2'b11;
    else rs <= {rs[0], 1'b0};
  assign rst = rs[1];
  rr_arb2 u_arb (
    .clk(CLK),
    .rst(rst),
    .req_i(bus.i_req),
    .req_d(bus.d_req),
    .en(state == IDLE),
    .valid(gv),
    .grant(grant)
  );
  assign timeout = cnt == LAST;
  always_ff @(posedge CLK or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE  ? (gv ? ISSUE : IDLE) :
          state == ISSUE ? WAIT :
          state == WAIT  ? ((bus.ad_ready | timeout) ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge CLK or posedge rst)
    if (rst) begin
      owner_q <= OWN_I;
      we_q <= 1'b0;
      err_q <= 1'b0;
      cnt <= '0;
      addr_q <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      if (state == IDLE && gv) begin
        owner_q <= grant;
        we_q <= (grant == OWN_D) & bus.d_we;
        addr_q <= ((grant == OWN_D) ? bus.d_addr : bus.i_addr) & AMASK;
        wline_q <= ((grant == OWN_D) && bus.d_we) ? bus.d_wline : '0;
        err_q <= 1'b0;
        rline_q <= '0;
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (bus.ad_ready) rline_q <= bus.ad_rline;
        // ready in the final counted cycle still beats the timeout
        err_q <= ~bus.ad_ready & timeout;
      end
    end
  always_comb begin
    rsp = state == RESP;
    act = (state == ISSUE) | (state == WAIT);
    bus.i_ack = rsp & (owner_q == OWN_I);
    bus.d_ack = rsp & (owner_q == OWN_D);
    bus.i_err = bus.i_ack & err_q;
    bus.d_err = bus.d_ack & err_q;
    bus.i_line = (bus.i_ack & ~err_q) ? rline_q : '0;
    bus.d_line = (bus.d_ack & ~err_q & ~we_q) ? rline_q : '0;
    bus.ad_re = (state == ISSUE) & ~we_q;
    bus.ad_we = (state == ISSUE) & we_q;
    bus.ad_addr = act ? addr_q : '0;
    bus.ad_wline = act ? wline_q : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus contention and reset sequences for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.CLK(clk), .RST(rst), .bus(bus));
  typedef struct {
    logic         is_d;
    logic         we;
    logic [31:0]  addr;
    logic [255:0] wline;
    logic [255:0] rline;
    int           n;
    logic [31:0]  exp_addr;
    logic         exp_err;
    logic [255:0] exp_line;
  } vec_t;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic wait_strobe(input int lim, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(bus.ad_re | bus.ad_we) && lat < lim);
  endtask
  task automatic txn(input vec_t v);
    int lat, stray, w;
    logic [255:0] exp_wl;
    exp_wl = (v.is_d && v.we) ? v.wline : '0;
    if (v.is_d) begin
      bus.d_req = 1'b1;
      bus.d_we = v.we;
      bus.d_addr = v.addr;
      bus.d_wline = v.wline;
    end else begin
      bus.i_req = 1'b1;
      bus.i_addr = v.addr;
    end
    wait_strobe(20, lat);
    chk("grant_latency", lat, 1);
    chk("ad_re", bus.ad_re, !(v.is_d && v.we));
    chk("ad_we", bus.ad_we, v.is_d && v.we);
    chk("ad_addr", bus.ad_addr, v.exp_addr);
    chk("ad_wline", bus.ad_wline, exp_wl);
    stray = 0;
    w = (v.n == 0) ? 64 : v.n;
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      if (bus.ad_re | bus.ad_we | bus.i_ack | bus.d_ack) stray++;
      if (bus.ad_addr !== v.exp_addr || bus.ad_wline !== exp_wl) stray++;
      if (k == v.n) begin
        bus.ad_ready = 1'b1;
        bus.ad_rline = v.rline;
      end
    end
    chk("wait_quiet", stray, 0);
    @(negedge clk);
    bus.ad_ready = 1'b0;
    bus.ad_rline = '0;
    chk("own_ack", v.is_d ? bus.d_ack : bus.i_ack, 1);
    chk("other_ack", v.is_d ? bus.i_ack : bus.d_ack, 0);
    chk("own_err", v.is_d ? bus.d_err : bus.i_err, v.exp_err);
    chk("own_line", v.is_d ? bus.d_line : bus.i_line, v.exp_line);
    chk("other_line", v.is_d ? bus.i_line : bus.d_line, 0);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("ack_pulse", {bus.i_ack, bus.d_ack, bus.ad_addr}, 0);
  endtask
  vec_t vecs[7];
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, bad;
    logic [255:0] ln;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, '0, {32{8'hA5}}, 9, 32'h0000_1220, 1'b0, {32{8'hA5}}};
    vecs[1] = '{1'b1, 1'b1, 32'h8000_0040, {2{128'h00112233445566778899AABBCCDDEEFF}},
                {8{32'hDEAD_BEEF}}, 4, 32'h8000_0040, 1'b0, '0};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_007F, '0, {8{32'h0BAD_F00D}}, 1, 32'h8000_0060, 1'b0, {8{32'h0BAD_F00D}}};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, '0, {8{32'h1234_5678}}, 2, 32'hFFFF_FFE0, 1'b0, {8{32'h1234_5678}}};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0100, '0, '0, 0, 32'h0000_0100, 1'b1, '0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0047, '0, {8{32'hCAFE_BABE}}, 64, 32'h0000_0040, 1'b0, {8{32'hCAFE_BABE}}};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0020, {8{32'h5A5A_0F0F}}, '0, 0, 32'h0000_0020, 1'b1, '0};
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wline = 0; bus.ad_ready = 0; bus.ad_rline = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.i_ack, bus.d_ack, bus.i_err, bus.d_err, bus.ad_re, bus.ad_we,
                          bus.ad_addr, bus.i_line | bus.d_line | bus.ad_wline}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // contention: I wins first, then strict alternation
    bus.i_addr = 32'h0000_1000;
    bus.d_addr = 32'h0000_2000;
    bus.d_we = 1'b0;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_strobe(20, lat);
      chk("rr_latency", lat, (g == 0) ? 1 : 2);
      chk("rr_addr", bus.ad_addr, (g % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      ln = {8{32'(g + 1)}};
      @(negedge clk);
      bus.ad_ready = 1'b1;
      bus.ad_rline = ln;
      @(negedge clk);
      bus.ad_ready = 1'b0;
      chk("rr_ack", {bus.i_ack, bus.d_ack}, (g % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_line", (g % 2 == 0) ? bus.i_line : bus.d_line, ln);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) txn(vecs[i]);
    // reset while a D fill waits, then a stray ad_ready
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h0000_3000;
    wait_strobe(20, lat);
    chk("mid_grant", bus.ad_re, 1);
    repeat (3) @(negedge clk);
    chk("mid_wait_addr", bus.ad_addr, 32'h0000_3000);
    rst = 1'b1;
    #1;
    chk("rst_async", {bus.ad_addr, bus.ad_re, bus.ad_we, bus.i_ack, bus.d_ack}, 0);
    bus.d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.ad_ready = 1'b1;
    bus.ad_rline = {8{32'hFFFF_FFFF}};
    @(negedge clk);
    bus.ad_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.ad_re | bus.ad_we | bus.i_ack | bus.d_ack | (|bus.d_line)) bad++;
    end
    chk("stray_ready_ignored", bad, 0);
    bus.i_addr = 32'h0000_4444;
    bus.d_addr = 32'h0000_5555;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    wait_strobe(20, lat);
    chk("post_rst_i_first", bus.ad_addr, 32'h0000_4440);
    @(negedge clk);
    bus.ad_ready = 1'b1;
    bus.ad_rline = {8{32'h7777_0000}};
    @(negedge clk);
    bus.ad_ready = 1'b0;
    chk("post_rst_i_ack", {bus.i_ack, bus.i_err, bus.d_ack}, 3'b100);
    bus.i_req = 1'b0;
    wait_strobe(20, lat);
    chk("post_rst_d_addr", bus.ad_addr, 32'h0000_5540);
    @(negedge clk);
    bus.ad_ready = 1'b1;
    bus.ad_rline = {8{32'h3333_CCCC}};
    @(negedge clk);
    bus.ad_ready = 1'b0;
    chk("post_rst_d_line", bus.d_line, {8{32'h3333_CCCC}});
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
